// File: rtl/sc2110_pkg.sv
// rtl/sc2110_pkg.sv - SC2110 sync-code constants and alignment FSM state encoding
package sc2110_pkg;

   localparam logic [11:0] SYNC_PRE0 = 12'hFFF;
   localparam logic [11:0] SYNC_PRE1 = 12'h000;
   localparam logic [11:0] SAV_ACT   = 12'h800;
   localparam logic [11:0] EAV_ACT   = 12'h9D0;
   localparam logic [11:0] SAV_BLK   = 12'hAB0;
   localparam logic [11:0] EAV_BLK   = 12'hB60;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_SEARCH = 3'd2,
      ST_SLIP   = 3'd3,
      ST_LOCKED = 3'd4,
      ST_ERROR  = 3'd5
   } align_state_t;

   function automatic logic is_sync_code(input logic [11:0] w);
      return (w == SAV_ACT) || (w == EAV_ACT) || (w == SAV_BLK) || (w == EAV_BLK);
   endfunction

endpackage

// File: rtl/sc2110_sync_detect.sv
// rtl/sc2110_sync_detect.sv - FFF,000,000,X header detector with registered one-cycle hit
module sc2110_sync_detect
   import sc2110_pkg::*;
#(
   parameter int DATA_W = 12
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic              I_clr,
   input  logic              I_data_valid,
   input  logic [DATA_W-1:0] I_data,
   output logic              O_hit
);

   // hist2 is the oldest word; only valid words shift, so gaps never break a header
   logic [DATA_W-1:0] hist0, hist1, hist2;
   logic              pre_ok;

   assign pre_ok = (hist2 == DATA_W'(SYNC_PRE0)) &&
                   (hist1 == DATA_W'(SYNC_PRE1)) &&
                   (hist0 == DATA_W'(SYNC_PRE1));

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         hist0 <= '0;
         hist1 <= '0;
         hist2 <= '0;
         O_hit <= 1'b0;
      end else if (I_clr) begin
         hist0 <= '0;
         hist1 <= '0;
         hist2 <= '0;
         O_hit <= 1'b0;
      end else begin
         O_hit <= I_data_valid && pre_ok && is_sync_code(12'(I_data));
         if (I_data_valid) begin
            hist2 <= hist1;
            hist1 <= hist0;
            hist0 <= I_data;
         end
      end
   end

endmodule

// File: rtl/sc2110_align_ctrl.sv
// rtl/sc2110_align_ctrl.sv - SC2110 LVDS word-alignment FSM driving deserializer bitslip
module sc2110_align_ctrl
   import sc2110_pkg::*;
#(
   parameter int DATA_W     = 12,
   parameter int SETTLE_CYC = 16,
   parameter int SEARCH_CYC = 4096,
   parameter int HIT_NEED   = 4,
   parameter int MAX_SLIP   = 24,
   parameter int LOSS_CYC   = 65536
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic              I_start,
   input  logic              I_data_valid,
   input  logic [DATA_W-1:0] I_data,
   output logic              O_bitslip,
   output logic              O_bitslip_done,
   output logic              O_bitslip_error,
   output logic [4:0]        O_slip_cnt,
   output logic [2:0]        O_state
);

   localparam int SET_W  = $clog2(SETTLE_CYC);
   localparam int WIN_W  = $clog2(SEARCH_CYC);
   localparam int HIT_W  = $clog2(HIT_NEED + 1);
   localparam int LOSS_W = $clog2(LOSS_CYC);

   align_state_t      state, state_nxt;
   logic              bitslip_nxt, done_nxt, error_nxt;
   logic              hit;
   logic [SET_W-1:0]  settle_cnt;
   logic [WIN_W-1:0]  win_cnt;
   logic [HIT_W-1:0]  hit_cnt;
   logic [LOSS_W-1:0] loss_cnt;
   logic [4:0]        slip_cnt;
   logic              settle_end, win_end, lock_now, loss_end, slip_clr;

   sc2110_sync_detect #(.DATA_W(DATA_W)) u_detect (
      .I_clk        (I_clk),
      .I_rst        (I_rst),
      .I_clr        (state == ST_SETTLE),
      .I_data_valid (I_data_valid),
      .I_data       (I_data),
      .O_hit        (hit)
   );

   assign settle_end = (settle_cnt == SET_W'(SETTLE_CYC - 1));
   assign win_end    = (win_cnt == WIN_W'(SEARCH_CYC - 1));
   // a hit on the last window clock still counts before expiry is considered
   assign lock_now   = hit && (hit_cnt == HIT_W'(HIT_NEED - 1));
   assign loss_end   = !hit && (loss_cnt == LOSS_W'(LOSS_CYC - 1));
   assign slip_clr   = ((state == ST_IDLE || state == ST_ERROR) && I_start) ||
                       (state == ST_LOCKED && loss_end);

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state           <= ST_IDLE;
         O_bitslip       <= 1'b0;
         O_bitslip_done  <= 1'b0;
         O_bitslip_error <= 1'b0;
      end else begin
         state           <= state_nxt;
         O_bitslip       <= bitslip_nxt;
         O_bitslip_done  <= done_nxt;
         O_bitslip_error <= error_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (I_start) state_nxt = ST_SETTLE;
         ST_SETTLE: if (settle_end) state_nxt = ST_SEARCH;
         ST_SEARCH: begin
            if (lock_now)
               state_nxt = ST_LOCKED;
            else if (win_end)
               state_nxt = (slip_cnt == 5'(MAX_SLIP)) ? ST_ERROR : ST_SLIP;
         end
         ST_SLIP:   state_nxt = ST_SETTLE;
         ST_LOCKED: if (loss_end) state_nxt = ST_SETTLE;
         ST_ERROR:  if (I_start) state_nxt = ST_SETTLE;
         default:   state_nxt = ST_IDLE;
      endcase
      bitslip_nxt = (state_nxt == ST_SLIP);
      done_nxt    = (state_nxt == ST_LOCKED);
      error_nxt   = (state_nxt == ST_ERROR);
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         settle_cnt <= '0;
         win_cnt    <= '0;
         hit_cnt    <= '0;
         loss_cnt   <= '0;
         slip_cnt   <= '0;
      end else begin
         settle_cnt <= (state == ST_SETTLE && !settle_end) ? settle_cnt + 1'b1 : '0;
         win_cnt    <= (state == ST_SEARCH && !win_end) ? win_cnt + 1'b1 : '0;
         loss_cnt   <= (state == ST_LOCKED && !hit) ? loss_cnt + 1'b1 : '0;
         if (state != ST_SEARCH)
            hit_cnt <= '0;
         else if (hit && hit_cnt < HIT_W'(HIT_NEED))
            hit_cnt <= hit_cnt + 1'b1;
         if (slip_clr)
            slip_cnt <= '0;
         else if (state == ST_SLIP && slip_cnt != 5'(MAX_SLIP))
            slip_cnt <= slip_cnt + 1'b1;
      end
   end

   assign O_slip_cnt = slip_cnt;
   assign O_state    = state;

endmodule
